// File: rtl/hevc_bin_pkg.sv
// +----------------------------------------------------------------------------+
// | hevc_bin_pkg : shared types for the KTR bin-string serializer              |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package hevc_bin_pkg;

  // Stored string width; the serializer's BIN_WIDTH must match this.
  localparam int C_BIN_WIDTH = 16;
  localparam int LEN_W       = $clog2(C_BIN_WIDTH + 1);

  typedef struct packed {
    logic [C_BIN_WIDTH-1:0] bin;
    logic [LEN_W-1:0]       len;
  } bin_str_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/bin_str_fifo.sv
// +----------------------------------------------------------------------------+
// | bin_str_fifo : synchronous FIFO of bin strings with full/empty flags       |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin_str_fifo
  import hevc_bin_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en,
  input  bin_str_t wr_data,
  input  logic     rd_en,
  output bin_str_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  bin_str_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = rd_en && !empty;
  // A pop frees the slot the same cycle, so a full FIFO can still take a write.
  assign w_push  = wr_en && (!full || w_pop);
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ktr_bin_serializer.sv
// +----------------------------------------------------------------------------+
// | ktr_bin_serializer : buffers KTR bin strings and emits them MSB-first,     |
// |                      one bin per cycle, with a per-string last marker      |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module ktr_bin_serializer
  import hevc_bin_pkg::*;
#(
  parameter int BIN_WIDTH  = C_BIN_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic [BIN_WIDTH-1:0] bin_len_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_bin_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 len_err_o
);

  ser_state_t           r_state;
  ser_state_t           w_state_nxt;
  logic [BIN_WIDTH-1:0] r_sh;
  logic [BIN_WIDTH-1:0] w_sh_nxt;
  logic [LEN_W-1:0]     r_rem;
  logic [LEN_W-1:0]     w_rem_nxt;
  logic                 r_len_err;

  bin_str_t             w_push_str;
  bin_str_t             w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_accept;
  logic                 w_len_over;
  logic                 w_pop;
  logic                 w_fire;
  logic [LEN_W-1:0]     w_shamt;

  // Input side: clamp over-long lengths before they reach the FIFO.
  assign w_accept       = in_valid_i && in_ready_o;
  assign w_len_over     = (bin_len_i > BIN_WIDTH'(BIN_WIDTH));
  assign w_push_str.bin = bin_i;
  assign w_push_str.len = w_len_over ? LEN_W'(BIN_WIDTH) : bin_len_i[LEN_W-1:0];

  bin_str_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_accept),
    .wr_data (w_push_str),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign in_ready_o  = !w_fifo_full;
  assign out_valid_o = (r_state == SHIFT);
  assign out_bin_o   = r_sh[BIN_WIDTH-1];
  assign out_last_o  = (r_rem == LEN_W'(1));
  assign busy_o      = !w_fifo_empty || (r_rem != '0);
  assign len_err_o   = r_len_err;

  assign w_fire  = out_valid_o && out_ready_i;
  // Left-justify so the first bin sits in the MSB; bits above len fall off.
  assign w_shamt = LEN_W'(BIN_WIDTH) - w_head.len;

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !w_fifo_empty;
      end
      SHIFT: begin
        if (w_fire) begin
          w_sh_nxt  = r_sh << 1;
          w_rem_nxt = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_pop       = !w_fifo_empty;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A zero-length string pops with rem=0 and leaves the engine idle.
    if (w_pop) begin
      w_sh_nxt    = w_head.bin << w_shamt;
      w_rem_nxt   = w_head.len;
      w_state_nxt = (w_head.len != '0) ? SHIFT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else if (w_accept && w_len_over) begin
      r_len_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ktr_bin_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_ktr_bin_serializer : directed self-checking bench for the serializer    |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ktr_bin_serializer;

  localparam int BW = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] bin       = '0;
  logic [BW-1:0] bin_len   = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_bin;
  logic          out_last;
  logic          busy;
  logic          len_err;

  int n_vec  = 0;
  int n_miss = 0;
  int span;

  always #5 clk = ~clk;

  ktr_bin_serializer #(
    .BIN_WIDTH  (BW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .bin_i       (bin),
    .bin_len_i   (bin_len),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_bin_o   (out_bin),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .len_err_o   (len_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every sample/drive point sits 1 ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] b, input logic [BW-1:0] l);
    int t;
    in_valid = 1'b1;
    bin      = b;
    bin_len  = l;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (!in_ready) check("push_ready_timeout", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    bin_len  = '0;
  endtask

  // Beat i expects bits[n-1-i] / lasts[n-1-i]; sp = cycles from first to last beat.
  task automatic collect(input string tag, input logic [63:0] bits, input logic [63:0] lasts,
                         input int n, output int sp);
    int i;
    int cyc;
    int first;
    i = 0;
    cyc = 0;
    first = -1;
    sp = -1;
    out_ready = 1'b1;
    while (i < n && cyc < 400) begin
      if (out_valid) begin
        if (first < 0) first = cyc;
        check({tag, "_bin"}, out_bin, bits[n-1-i]);
        check({tag, "_last"}, out_last, lasts[n-1-i]);
        i++;
        if (i == n) sp = cyc - first;
      end
      step();
      cyc++;
    end
    if (i < n) check({tag, "_timeout"}, i, n);
  endtask

  task automatic ktr_model(input int n, output logic [BW-1:0] v, output int l);
    int p;
    if (n >= 8) begin
      v = 16'h000F;
      l = 4;
    end else begin
      p = n >> 1;
      v = BW'((((1 << p) - 1) << 2) | (n & 1));
      l = p + 2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] kv;
    int            kl;

    // Reset values
    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bin", out_bin, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Single string 0x000B/4 -> 1,0,1,1; first bin two cycles after accept
    out_ready = 1'b1;
    push(16'h000B, 16'd4);
    check("single_t1_valid", out_valid, 1'b0);
    check("single_t1_busy", busy, 1'b1);
    step();
    check("single_t2_valid", out_valid, 1'b1);
    collect("single", 64'hB, 64'h1, 4, span);
    check("single_span", span, 3);
    check("single_busy_done", busy, 1'b0);
    check("single_valid_done", out_valid, 1'b0);

    // Back-to-back 0x5/3 then 0x2/2 -> 1,0,1,1,0 with no bubble
    push(16'h0005, 16'd3);
    push(16'h0002, 16'd2);
    collect("b2b", 64'b10110, 64'b00101, 5, span);
    check("b2b_span", span, 4);

    // Backpressure: three strings, two buffered plus one in the shifter
    out_ready = 1'b0;
    push(16'h000B, 16'd4);
    push(16'h0005, 16'd3);
    push(16'h0003, 16'd2);
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_bin", out_bin, 1'b1);
    check("bp_hold_last", out_last, 1'b0);
    step();
    step();
    step();
    check("bp_hold_ready2", in_ready, 1'b0);
    check("bp_hold_bin2", out_bin, 1'b1);
    check("bp_hold_valid2", out_valid, 1'b1);
    collect("bp", 64'b101110111, 64'b000100101, 9, span);
    check("bp_span", span, 8);
    check("bp_ready_after", in_ready, 1'b1);

    // Zero-length string is absorbed; stray upper bits of bin_i ignored
    push(16'hFFFF, 16'd0);
    push(16'hFFF1, 16'd1);
    collect("zl", 64'h1, 64'h1, 1, span);
    for (int k = 0; k < 3; k++) begin
      check("zl_no_extra", out_valid, 1'b0);
      step();
    end
    check("zl_busy", busy, 1'b0);

    // Clamp: len 20 stored as 16, sticky error flag
    check("clamp_err_pre", len_err, 1'b0);
    push(16'hA5C3, 16'd20);
    check("clamp_err_set", len_err, 1'b1);
    collect("clamp", 64'hA5C3, 64'h1, 16, span);
    check("clamp_span", span, 15);
    step();
    check("clamp_err_sticky", len_err, 1'b1);
    check("clamp_idle", out_valid, 1'b0);

    // Asynchronous reset during beat 2 of 0xFFFF/16
    out_ready = 1'b1;
    push(16'hFFFF, 16'd16);
    step();
    check("mrst_beat1_valid", out_valid, 1'b1);
    step();
    check("mrst_beat2_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_bin", out_bin, 1'b0);
    check("mrst_out_last", out_last, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_len_err", len_err, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mrst_quiet_valid", out_valid, 1'b0);
      check("mrst_quiet_busy", busy, 1'b0);
    end

    // KTR sweep, K=1, cMax=8, N=0..12
    for (int n = 0; n <= 12; n++) begin
      ktr_model(n, kv, kl);
      push(kv, BW'(kl));
      collect("ktr", {48'h0, kv}, 64'h1, kl, span);
      check("ktr_span", span, kl - 1);
    end
    step();
    check("ktr_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
